// File: rtl/dispatch_arbiter.sv
// dispatch_arbiter
// Holds decoded instructions in a small in-order FIFO and hands the head entry
// to one execution-unit class (ALU, LSU, BRU, VEC) over a shared payload bus.
// Each class has its own valid/ready handshake. Scalar memory ops and vector
// ops are kept ordered through an outstanding-LSU counter and the vec_busy
// input. Unknown instruction types are retired as illegal and never dispatched.

module dispatch_arbiter #(
   parameter int XLEN       = 32,
   parameter int INST_WIDTH = 32,
   parameter int DEPTH      = 2,
   parameter int LSU_MAX    = 7,
   localparam int LSU_CW    = $clog2(LSU_MAX + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  valid_in,
   input  logic [3:0]            instr_type_in,
   input  logic [XLEN-1:0]       pc_in,
   input  logic [INST_WIDTH-1:0] instr_in,
   output logic                  stall_out,
   output logic [3:0]            disp_valid,
   input  logic [3:0]            disp_ready,
   output logic [3:0]            disp_type,
   output logic [XLEN-1:0]       disp_pc,
   output logic [INST_WIDTH-1:0] disp_instr,
   input  logic                  vec_busy,
   input  logic                  lsu_done,
   output logic [LSU_CW-1:0]     lsu_outstanding,
   output logic                  illegal_out,
   output logic [XLEN-1:0]       illegal_pc
);

   // Instruction type codes shared with the decode stage
   localparam logic [3:0] ITYPE_ALU     = 4'd0;
   localparam logic [3:0] ITYPE_ALU_IMM = 4'd1;
   localparam logic [3:0] ITYPE_LOAD    = 4'd2;
   localparam logic [3:0] ITYPE_STORE   = 4'd3;
   localparam logic [3:0] ITYPE_BRANCH  = 4'd4;
   localparam logic [3:0] ITYPE_JAL     = 4'd5;
   localparam logic [3:0] ITYPE_JALR    = 4'd6;
   localparam logic [3:0] ITYPE_VEC     = 4'd7;

   // One-hot class encodings, bit order {VEC,BRU,LSU,ALU}
   localparam logic [3:0] CLASS_ALU = 4'b0001;
   localparam logic [3:0] CLASS_LSU = 4'b0010;
   localparam logic [3:0] CLASS_BRU = 4'b0100;
   localparam logic [3:0] CLASS_VEC = 4'b1000;

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int ENTRY_W = 4 + XLEN + INST_WIDTH;

   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [LSU_CW-1:0] LSU_LIMIT = LSU_CW'(LSU_MAX);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;

   logic                  head_valid;
   logic [3:0]            head_type;
   logic [XLEN-1:0]       head_pc;
   logic [INST_WIDTH-1:0] head_instr;
   logic [3:0]            head_class;
   logic                  head_unknown;
   logic [3:0]            blocked;
   logic                  enq;
   logic                  deq;
   logic                  fire;
   logic                  lsu_fire;
   logic                  unknown_retire;
   logic                  lsu_dec;

   assign head_valid = (count != '0);
   assign {head_type, head_pc, head_instr} = mem[rd_ptr];

   assign stall_out  = (count == CNT_FULL);
   assign disp_type  = head_type;
   assign disp_pc    = head_pc;
   assign disp_instr = head_instr;

   assign enq            = valid_in && !stall_out && !flush;
   assign fire           = |(disp_valid & disp_ready);
   assign lsu_fire       = disp_valid[1] && disp_ready[1];
   assign unknown_retire = head_valid && head_unknown && !flush;
   assign deq            = fire || unknown_retire;
   assign lsu_dec        = lsu_done && (lsu_outstanding != '0);

   // Map the head instruction type onto its execution-unit class
   always_comb begin
      head_class   = 4'b0000;
      head_unknown = 1'b0;
      case (head_type)
         ITYPE_ALU, ITYPE_ALU_IMM:           head_class = CLASS_ALU;
         ITYPE_LOAD, ITYPE_STORE:            head_class = CLASS_LSU;
         ITYPE_BRANCH, ITYPE_JAL, ITYPE_JALR: head_class = CLASS_BRU;
         ITYPE_VEC:                          head_class = CLASS_VEC;
         default:                            head_unknown = 1'b1;
      endcase
   end

   // Hold scalar memory ops behind vector memory traffic or a full LSU, and
   // hold vector ops until every scalar memory op has completed
   always_comb begin
      blocked    = 4'b0000;
      blocked[1] = vec_busy || (lsu_outstanding == LSU_LIMIT);
      blocked[3] = (lsu_outstanding != '0);
   end

   // Offer the head to its class only when it is valid, unblocked and not flushed
   always_comb begin
      disp_valid = 4'b0000;
      if (head_valid && !flush) begin
         disp_valid = head_class & ~blocked;
      end
   end

   // FIFO storage is only meaningful while counted, so it needs no reset
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[wr_ptr] <= {instr_type_in, pc_in, instr_in};
      end
   end

   // Occupancy and pointers; flush drops everything queued at the edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (deq) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (enq && !deq) begin
            count <= count + CNT_W'(1);
         end else if (!enq && deq) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Track scalar memory ops in flight; flush leaves them alone since they still complete
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lsu_outstanding <= '0;
      end else if (lsu_fire && !lsu_dec) begin
         lsu_outstanding <= lsu_outstanding + LSU_CW'(1);
      end else if (!lsu_fire && lsu_dec) begin
         lsu_outstanding <= lsu_outstanding - LSU_CW'(1);
      end
   end

   // Report an unknown instruction as a one-cycle pulse and remember its PC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_out <= 1'b0;
         illegal_pc  <= '0;
      end else begin
         illegal_out <= unknown_retire;
         if (unknown_retire) begin
            illegal_pc <= head_pc;
         end
      end
   end

endmodule

// File: tb/tb_dispatch_arbiter.sv
// tb_dispatch_arbiter
// Directed vectors for dispatch_arbiter with hand-computed expected values.
// Inputs change 1 time unit after each rising edge and outputs are sampled
// 2 time units after the edge, well clear of the next edge.

module tb_dispatch_arbiter;

   localparam logic [3:0] ITYPE_ALU     = 4'd0;
   localparam logic [3:0] ITYPE_ALU_IMM = 4'd1;
   localparam logic [3:0] ITYPE_LOAD    = 4'd2;
   localparam logic [3:0] ITYPE_STORE   = 4'd3;
   localparam logic [3:0] ITYPE_BRANCH  = 4'd4;
   localparam logic [3:0] ITYPE_JAL     = 4'd5;
   localparam logic [3:0] ITYPE_VEC     = 4'd7;
   localparam logic [3:0] ITYPE_BAD     = 4'hF;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        valid_in;
   logic [3:0]  instr_type_in;
   logic [31:0] pc_in;
   logic [31:0] instr_in;
   logic        stall_out;
   logic [3:0]  disp_valid;
   logic [3:0]  disp_ready;
   logic [3:0]  disp_type;
   logic [31:0] disp_pc;
   logic [31:0] disp_instr;
   logic        vec_busy;
   logic        lsu_done;
   logic [2:0]  lsu_outstanding;
   logic        illegal_out;
   logic [31:0] illegal_pc;

   int vectorCount = 0;
   int missCount   = 0;

   dispatch_arbiter #(
      .XLEN(32), .INST_WIDTH(32), .DEPTH(2), .LSU_MAX(7)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .valid_in(valid_in),
      .instr_type_in(instr_type_in),
      .pc_in(pc_in),
      .instr_in(instr_in),
      .stall_out(stall_out),
      .disp_valid(disp_valid),
      .disp_ready(disp_ready),
      .disp_type(disp_type),
      .disp_pc(disp_pc),
      .disp_instr(disp_instr),
      .vec_busy(vec_busy),
      .lsu_done(lsu_done),
      .lsu_outstanding(lsu_outstanding),
      .illegal_out(illegal_out),
      .illegal_pc(illegal_pc)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] t,
                                input logic [31:0] pc, input logic [31:0] ins);
      valid_in      = v;
      instr_type_in = t;
      pc_in         = pc;
      instr_in      = ins;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      flush      = 1'b0;
      disp_ready = 4'b0000;
      vec_busy   = 1'b0;
      lsu_done   = 1'b0;
      applyStimulus(1'b0, ITYPE_ALU, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      settle();
      checkOutput("rst_stall", 32'(stall_out), 32'd0);
      checkOutput("rst_dvalid", 32'(disp_valid), 32'd0);
      checkOutput("rst_lsu", 32'(lsu_outstanding), 32'd0);
      checkOutput("rst_ill", 32'(illegal_out), 32'd0);
      checkOutput("rst_illpc", illegal_pc, 32'd0);

      // Back-to-back ALU, LOAD, JAL with every class ready
      disp_ready = 4'b1111;
      nextCycle();
      applyStimulus(1'b1, ITYPE_ALU, 32'h10, 32'h00000033);
      settle();
      checkOutput("b2b_empty", 32'(disp_valid), 32'h0);
      nextCycle();
      applyStimulus(1'b1, ITYPE_LOAD, 32'h14, 32'h00000003);
      settle();
      checkOutput("b2b_alu", 32'(disp_valid), 32'b0001);
      checkOutput("b2b_alu_pc", disp_pc, 32'h10);
      checkOutput("b2b_alu_ins", disp_instr, 32'h00000033);
      nextCycle();
      applyStimulus(1'b1, ITYPE_JAL, 32'h18, 32'h0000006F);
      settle();
      checkOutput("b2b_lsu", 32'(disp_valid), 32'b0010);
      checkOutput("b2b_lsu_pc", disp_pc, 32'h14);
      checkOutput("b2b_lsu_cnt0", 32'(lsu_outstanding), 32'd0);
      nextCycle();
      applyStimulus(1'b0, ITYPE_ALU, 32'h0, 32'h0);
      settle();
      checkOutput("b2b_bru", 32'(disp_valid), 32'b0100);
      checkOutput("b2b_bru_pc", disp_pc, 32'h18);
      checkOutput("b2b_lsu_cnt1", 32'(lsu_outstanding), 32'd1);
      lsu_done = 1'b1;
      nextCycle();
      lsu_done = 1'b0;
      settle();
      checkOutput("b2b_idle", 32'(disp_valid), 32'h0);
      checkOutput("b2b_lsu_clr", 32'(lsu_outstanding), 32'd0);

      // Fill with ready low, third instruction must be refused
      disp_ready = 4'b0000;
      applyStimulus(1'b1, ITYPE_ALU, 32'h20, 32'h1);
      settle();
      checkOutput("full_stall0", 32'(stall_out), 32'd0);
      nextCycle();
      applyStimulus(1'b1, ITYPE_ALU_IMM, 32'h24, 32'h2);
      settle();
      checkOutput("full_stall1", 32'(stall_out), 32'd0);
      checkOutput("full_hold_dv", 32'(disp_valid), 32'b0001);
      checkOutput("full_hold_pc", disp_pc, 32'h20);
      nextCycle();
      applyStimulus(1'b1, ITYPE_BRANCH, 32'h28, 32'h3);
      settle();
      checkOutput("full_stall2", 32'(stall_out), 32'd1);
      nextCycle();
      applyStimulus(1'b0, ITYPE_ALU, 32'h0, 32'h0);
      disp_ready = 4'b1111;
      settle();
      checkOutput("drain0_dv", 32'(disp_valid), 32'b0001);
      checkOutput("drain0_pc", disp_pc, 32'h20);
      checkOutput("drain0_stall", 32'(stall_out), 32'd1);
      nextCycle();
      settle();
      checkOutput("drain1_stall", 32'(stall_out), 32'd0);
      checkOutput("drain1_dv", 32'(disp_valid), 32'b0001);
      checkOutput("drain1_pc", disp_pc, 32'h24);
      checkOutput("drain1_type", 32'(disp_type), 32'(ITYPE_ALU_IMM));
      nextCycle();
      settle();
      checkOutput("drain_empty", 32'(disp_valid), 32'h0);

      // Two LOADs in flight, then a VEC waits for them to complete
      applyStimulus(1'b1, ITYPE_LOAD, 32'h30, 32'h0);
      nextCycle();
      applyStimulus(1'b1, ITYPE_LOAD, 32'h34, 32'h0);
      nextCycle();
      applyStimulus(1'b1, ITYPE_VEC, 32'h38, 32'h57);
      settle();
      checkOutput("ord_cnt1", 32'(lsu_outstanding), 32'd1);
      nextCycle();
      applyStimulus(1'b0, ITYPE_ALU, 32'h0, 32'h0);
      settle();
      checkOutput("ord_cnt2", 32'(lsu_outstanding), 32'd2);
      checkOutput("ord_vec_blk2", 32'(disp_valid), 32'h0);
      lsu_done = 1'b1;
      nextCycle();
      lsu_done = 1'b0;
      settle();
      checkOutput("ord_cnt_dn1", 32'(lsu_outstanding), 32'd1);
      checkOutput("ord_vec_blk1", 32'(disp_valid), 32'h0);
      lsu_done = 1'b1;
      nextCycle();
      lsu_done = 1'b0;
      settle();
      checkOutput("ord_cnt_dn0", 32'(lsu_outstanding), 32'd0);
      checkOutput("ord_vec_go", 32'(disp_valid), 32'b1000);
      checkOutput("ord_vec_pc", disp_pc, 32'h38);
      nextCycle();
      applyStimulus(1'b1, ITYPE_LOAD, 32'h3C, 32'h0);
      settle();
      checkOutput("ord_vec_gone", 32'(disp_valid), 32'h0);
      nextCycle();
      applyStimulus(1'b0, ITYPE_ALU, 32'h0, 32'h0);
      nextCycle();
      applyStimulus(1'b1, ITYPE_LOAD, 32'h40, 32'h0);
      settle();
      checkOutput("sim_pre_cnt", 32'(lsu_outstanding), 32'd1);
      nextCycle();
      applyStimulus(1'b0, ITYPE_ALU, 32'h0, 32'h0);
      lsu_done = 1'b1;
      settle();
      checkOutput("sim_fire_dv", 32'(disp_valid), 32'b0010);
      nextCycle();
      lsu_done = 1'b0;
      settle();
      checkOutput("sim_cnt_same", 32'(lsu_outstanding), 32'd1);
      lsu_done = 1'b1;
      nextCycle();
      lsu_done = 1'b0;
      settle();
      checkOutput("sim_cnt_clr", 32'(lsu_outstanding), 32'd0);

      // STORE held by vec_busy, released in the same cycle vec_busy drops
      vec_busy = 1'b1;
      applyStimulus(1'b1, ITYPE_STORE, 32'h50, 32'h23);
      nextCycle();
      applyStimulus(1'b0, ITYPE_ALU, 32'h0, 32'h0);
      settle();
      checkOutput("vb_hold0", 32'(disp_valid), 32'h0);
      checkOutput("vb_type", 32'(disp_type), 32'(ITYPE_STORE));
      nextCycle();
      settle();
      checkOutput("vb_hold1", 32'(disp_valid), 32'h0);
      vec_busy = 1'b0;
      settle();
      checkOutput("vb_release", 32'(disp_valid), 32'b0010);
      checkOutput("vb_pc", disp_pc, 32'h50);
      nextCycle();
      settle();
      checkOutput("vb_cnt", 32'(lsu_outstanding), 32'd1);
      lsu_done = 1'b1;
      nextCycle();
      lsu_done = 1'b0;

      // Unknown type retires as illegal, following ALU dispatches normally
      applyStimulus(1'b1, ITYPE_BAD, 32'h100, 32'h0000007F);
      nextCycle();
      applyStimulus(1'b1, ITYPE_ALU, 32'h104, 32'h00000033);
      settle();
      checkOutput("ill_no_dv", 32'(disp_valid), 32'h0);
      checkOutput("ill_pre", 32'(illegal_out), 32'd0);
      nextCycle();
      applyStimulus(1'b0, ITYPE_ALU, 32'h0, 32'h0);
      settle();
      checkOutput("ill_pulse", 32'(illegal_out), 32'd1);
      checkOutput("ill_pc", illegal_pc, 32'h100);
      checkOutput("ill_next_dv", 32'(disp_valid), 32'b0001);
      checkOutput("ill_next_pc", disp_pc, 32'h104);
      nextCycle();
      settle();
      checkOutput("ill_drop", 32'(illegal_out), 32'd0);
      checkOutput("ill_pc_hold", illegal_pc, 32'h100);

      // Three LOADs in flight, fill the FIFO, then flush
      applyStimulus(1'b1, ITYPE_LOAD, 32'h200, 32'h0);
      nextCycle();
      applyStimulus(1'b1, ITYPE_LOAD, 32'h204, 32'h0);
      nextCycle();
      applyStimulus(1'b1, ITYPE_LOAD, 32'h208, 32'h0);
      nextCycle();
      applyStimulus(1'b0, ITYPE_ALU, 32'h0, 32'h0);
      nextCycle();
      settle();
      checkOutput("fl_cnt3", 32'(lsu_outstanding), 32'd3);
      disp_ready = 4'b0000;
      applyStimulus(1'b1, ITYPE_ALU, 32'h210, 32'h0);
      nextCycle();
      applyStimulus(1'b1, ITYPE_ALU, 32'h214, 32'h0);
      nextCycle();
      applyStimulus(1'b0, ITYPE_ALU, 32'h0, 32'h0);
      settle();
      checkOutput("fl_full", 32'(stall_out), 32'd1);
      disp_ready = 4'b1111;
      flush = 1'b1;
      settle();
      checkOutput("fl_dv_forced", 32'(disp_valid), 32'h0);
      nextCycle();
      flush = 1'b0;
      settle();
      checkOutput("fl_stall", 32'(stall_out), 32'd0);
      checkOutput("fl_empty_dv", 32'(disp_valid), 32'h0);
      checkOutput("fl_lsu_kept", 32'(lsu_outstanding), 32'd3);

      // Asynchronous reset in the middle of a cycle with an entry at the head
      disp_ready = 4'b0000;
      applyStimulus(1'b1, ITYPE_ALU, 32'h300, 32'h0);
      nextCycle();
      applyStimulus(1'b0, ITYPE_ALU, 32'h0, 32'h0);
      settle();
      checkOutput("ar_pre_dv", 32'(disp_valid), 32'b0001);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("ar_dv", 32'(disp_valid), 32'h0);
      checkOutput("ar_lsu", 32'(lsu_outstanding), 32'd0);
      checkOutput("ar_illpc", illegal_pc, 32'h0);
      checkOutput("ar_stall", 32'(stall_out), 32'd0);
      nextCycle();
      rst = 1'b0;
      disp_ready = 4'b1111;
      nextCycle();
      settle();
      checkOutput("ar_discard", 32'(disp_valid), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/dispatch_arbiter.md
Name: dispatch_arbiter

Overview:
- Sits between decode_stage and the execution units (ALU, LSU, BRU, VEC).
- Buffers decoded instructions in a small in-order FIFO and routes the head entry to one unit class over a shared payload bus with per-class valid/ready handshakes.
- Back-pressures decode via stall_out.
- Enforces scalar-memory/vector ordering and retires unknown opcodes as illegal.

Parameters:
- XLEN, 32, data/PC width
- INST_WIDTH, 32, instruction width
- DEPTH, 2, FIFO entries (power of two, >=2)
- LSU_MAX, 7, maximum outstanding scalar memory ops; counter width = clog2(LSU_MAX+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush
- valid_in  in  1  decoded instruction valid
- instr_type_in  in  4  ITYPE_* code from riscv_header
- pc_in  in  XLEN  instruction PC
- instr_in  in  INST_WIDTH  raw instruction
- stall_out  out  1  decode must hold; high when FIFO full
- disp_valid  out  4  one-hot, bit order {VEC,BRU,LSU,ALU}
- disp_ready  in  4  per-class ready, same bit order
- disp_type  out  4  head ITYPE code
- disp_pc  out  XLEN  head PC
- disp_instr  out  INST_WIDTH  head instruction
- vec_busy  in  1  vector unit has memory ops in flight
- lsu_done  in  1  one scalar memory op completed (1-cycle pulse)
- lsu_outstanding  out  clog2(LSU_MAX+1)  outstanding scalar memory ops
- illegal_out  out  1  1-cycle pulse, UNKNOWN instruction retired
- illegal_pc  out  XLEN  PC of the last illegal instruction

Behaviour:
- Reset (async, rst=1): FIFO count and pointers 0, lsu_outstanding 0, illegal_out 0, illegal_pc 0. Derived outputs are stall_out 0 and disp_valid 0. Reset mid-transfer discards all entries.
- Enqueue: valid_in && !stall_out && !flush; entry = {type, pc, instr}.
- stall_out = (count == DEPTH), decoded from registered count only. There is no same-cycle dequeue bypass.
- Latency: an entry enqueued at edge N appears at the head (disp_* valid) from cycle N+1. Operation is strictly in-order.
- Class map:
  - ALU, ALU_IMM -> ALU
  - LOAD, STORE -> LSU
  - BRANCH, JAL, JALR -> BRU
  - VEC -> VEC
  - any other code -> UNKNOWN
- disp_valid[c] = head_valid && class==c && !blocked(c) && !flush. At most one bit set.
- Blocking:
  - LSU is blocked when vec_busy, or when lsu_outstanding == LSU_MAX.
  - VEC is blocked when lsu_outstanding != 0.
  - ALU and BRU are never blocked.
- disp_valid is not sticky: it may drop if a block condition rises. Payload is stable while the head is unchanged.
- Fire = disp_valid[c] && disp_ready[c]. Fire dequeues the head at the clock edge. Simultaneous enqueue and dequeue keeps count unchanged.
- UNKNOWN head: dequeued unconditionally in its first head cycle (unless flush), with no disp_valid. illegal_out = 1 and illegal_pc = head PC are registered at that edge. illegal_out returns to 0 the next cycle.
- lsu_outstanding:
  - +1 on LSU fire; -1 on lsu_done.
  - Both in the same cycle: unchanged.
  - lsu_done at 0 is ignored (no underflow).
  - Increment cannot overflow because of the LSU block at LSU_MAX.
- Flush:
  - FIFO count and pointers clear at the edge.
  - Same-cycle enqueue suppressed; disp_valid forced 0.
  - illegal_out cleared.
  - lsu_outstanding is NOT cleared, because in-flight memory ops still complete.
- Pointers wrap modulo DEPTH.
- payload outputs are don't-care when no disp_valid bit is set. Verification checks them only when disp_valid != 0.

Test Plan:
- Back-to-back ALU, LOAD, JAL with all disp_ready=1 -> disp_valid 0001, 0010, 0100 on consecutive cycles starting 1 cycle after the first valid_in. lsu_outstanding goes 0->1.
- disp_ready=0, three valid_in pulses (DEPTH=2) -> stall_out rises after the second enqueue and the third instruction is not accepted. Raise ready -> entries drain in order and stall_out drops the cycle after the first fire.
- Issue 2 LOADs (lsu_outstanding=2), then VEC at head -> disp_valid stays 0000 until two lsu_done pulses. VEC dispatches the cycle lsu_outstanding reads 0. LSU fire plus lsu_done in the same cycle leaves the count unchanged.
- vec_busy=1 with a STORE at head -> no dispatch. Drop vec_busy -> disp_valid=0010 the same cycle.
- Opcode 7'b1111111 (UNKNOWN) at pc 0x100 followed by an ALU op -> illegal_out pulses 1 cycle with illegal_pc=0x100, and the ALU op dispatches next with no disp_valid for the illegal entry.
- Full FIFO with lsu_outstanding=3, assert flush -> count 0, stall_out 0, no disp_valid that cycle, lsu_outstanding stays 3. Assert rst mid-stream -> all outputs return to reset values immediately, without waiting for a clock edge.
